// File: rtl/cu_pkg.sv
// Shared types for the multi-cycle control unit: states, opcodes,
// ALU select codes, field widths, and the output decode helpers.
package cu_pkg;

  localparam int PC_W  = 7;
  localparam int IR_W  = 16;
  localparam int DA_W  = 8;
  localparam int RA_W  = 4;
  localparam int SEL_W = 3;

  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_LOAD_A   = 4'd3,
    S_LOAD_B   = 4'd4,
    S_STORE    = 4'd5,
    S_ALU_EXEC = 4'd6,
    S_HALT     = 4'd7
  } state_t;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'h0,
    OP_STORE = 4'h1,
    OP_LOAD  = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_HALT  = 4'h5,
    OP_XOR   = 4'h6,
    OP_OR    = 4'h7,
    OP_AND   = 4'h8,
    OP_INC   = 4'h9,
    OP_PASS  = 4'hA
  } opcode_t;

  localparam logic [SEL_W-1:0] ALU_NONE = 3'b000;
  localparam logic [SEL_W-1:0] ALU_ADD  = 3'b001;
  localparam logic [SEL_W-1:0] ALU_SUB  = 3'b010;
  localparam logic [SEL_W-1:0] ALU_PASS = 3'b011;
  localparam logic [SEL_W-1:0] ALU_XOR  = 3'b100;
  localparam logic [SEL_W-1:0] ALU_OR   = 3'b101;
  localparam logic [SEL_W-1:0] ALU_AND  = 3'b110;
  localparam logic [SEL_W-1:0] ALU_INC  = 3'b111;

  typedef struct packed {
    logic             ir_ld;
    logic [DA_W-1:0]  d_addr;
    logic             d_wr;
    logic             rf_s;
    logic [RA_W-1:0]  rf_w_addr;
    logic             rf_w_en;
    logic [RA_W-1:0]  rf_ra_addr;
    logic [RA_W-1:0]  rf_rb_addr;
    logic [SEL_W-1:0] alu_sel;
    logic             halted;
  } cu_out_t;

  function automatic logic [SEL_W-1:0] alu_sel_of(
    input logic [3:0] op
  );
    logic [SEL_W-1:0] sel;
    sel = ALU_NONE;
    case (op)
      OP_ADD:  sel = ALU_ADD;
      OP_SUB:  sel = ALU_SUB;
      OP_PASS: sel = ALU_PASS;
      OP_XOR:  sel = ALU_XOR;
      OP_OR:   sel = ALU_OR;
      OP_AND:  sel = ALU_AND;
      OP_INC:  sel = ALU_INC;
      default: sel = ALU_NONE;
    endcase
    return sel;
  endfunction

  function automatic cu_out_t outs_of(
    input state_t          s,
    input logic [IR_W-1:0] ir
  );
    cu_out_t o;
    o = '0;
    case (s)
      S_FETCH: o.ir_ld = 1'b1;
      S_LOAD_A: begin
        o.d_addr = ir[11:4];
        o.rf_s   = 1'b1;
      end
      S_LOAD_B: begin
        o.d_addr    = ir[11:4];
        o.rf_s      = 1'b1;
        o.rf_w_en   = 1'b1;
        o.rf_w_addr = ir[3:0];
      end
      S_STORE: begin
        o.d_addr     = ir[7:0];
        o.rf_ra_addr = ir[11:8];
        o.d_wr       = 1'b1;
      end
      S_ALU_EXEC: begin
        o.rf_ra_addr = ir[11:8];
        o.rf_rb_addr = ir[7:4];
        o.rf_w_addr  = ir[3:0];
        o.rf_w_en    = 1'b1;
        o.alu_sel    = alu_sel_of(ir[15:12]);
      end
      S_HALT: o.halted = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/program_counter.sv
// 7-bit instruction address counter; wraps 127 -> 0 silently.
// Ports: Clk, Reset (sync), Clr (sync clear), Up (increment), Addr.
module program_counter
  import cu_pkg::*;
(
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Clr,
  input  logic            Up,
  output logic [PC_W-1:0] Addr
);

  always_ff @(posedge Clk) begin
    if (Reset || Clr)
      Addr <= '0;
    else if (Up)
      Addr <= Addr + 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle Moore control unit: fetch/decode/execute sequencing
// for a 16-bit ISA; strobes and addresses are registered.
// Ports: Clk, Reset (sync), IR_In in; PC_Addr, IR_Ld, D_Addr,
// D_Wr, RF_s, RF_* addr/en, ALU_Sel, State, Halted out.
// Build option CU_TRAP_ILLEGAL_EN: undefined opcodes halt.
module control_unit
  import cu_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic [IR_W-1:0]  IR_In,
  output logic [PC_W-1:0]  PC_Addr,
  output logic             IR_Ld,
  output logic [DA_W-1:0]  D_Addr,
  output logic             D_Wr,
  output logic             RF_s,
  output logic [RA_W-1:0]  RF_W_Addr,
  output logic             RF_W_En,
  output logic [RA_W-1:0]  RF_Ra_Addr,
  output logic [RA_W-1:0]  RF_Rb_Addr,
  output logic [SEL_W-1:0] ALU_Sel,
  output logic [3:0]       State,
  output logic             Halted
);

  state_t          state, nxt;
  logic [IR_W-1:0] ir, ir_nxt;
  cu_out_t         outs;

  always_comb begin
    nxt    = state;
    ir_nxt = ir;
    unique case (state)
      S_INIT:  nxt = S_FETCH;
      S_FETCH: begin
        nxt    = S_DECODE;
        ir_nxt = IR_In;
      end
      S_DECODE: begin
        case (ir[15:12])
          OP_NOOP:  nxt = S_FETCH;
          OP_LOAD:  nxt = S_LOAD_A;
          OP_STORE: nxt = S_STORE;
          OP_HALT:  nxt = S_HALT;
          OP_ADD, OP_SUB, OP_XOR, OP_OR,
          OP_AND, OP_INC, OP_PASS:
            nxt = S_ALU_EXEC;
`ifdef CU_TRAP_ILLEGAL_EN
          default:  nxt = S_HALT;
`else
          default:  nxt = S_FETCH;
`endif
        endcase
      end
      S_LOAD_A:   nxt = S_LOAD_B;
      S_LOAD_B:   nxt = S_FETCH;
      S_STORE:    nxt = S_FETCH;
      S_ALU_EXEC: nxt = S_FETCH;
      S_HALT:     nxt = S_HALT;
      default:    nxt = S_INIT;
    endcase
  end

  // Outputs are decoded from the upcoming state so they
  // appear registered yet aligned with the state they describe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_INIT;
      ir    <= '0;
      outs  <= '0;
    end else begin
      state <= nxt;
      ir    <= ir_nxt;
      outs  <= outs_of(nxt, ir_nxt);
    end
  end

  program_counter u_pc (
    .Clk   (Clk),
    .Reset (Reset),
    .Clr   (state == S_INIT),
    .Up    (state == S_FETCH),
    .Addr  (PC_Addr)
  );

  assign State      = state;
  assign IR_Ld      = outs.ir_ld;
  assign D_Addr     = outs.d_addr;
  assign D_Wr       = outs.d_wr;
  assign RF_s       = outs.rf_s;
  assign RF_W_Addr  = outs.rf_w_addr;
  assign RF_W_En    = outs.rf_w_en;
  assign RF_Ra_Addr = outs.rf_ra_addr;
  assign RF_Rb_Addr = outs.rf_rb_addr;
  assign ALU_Sel    = outs.alu_sel;
  assign Halted     = outs.halted;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit.
// Expected values are hand-derived from the instruction timing.
module tb_control_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] IR_In;
  logic [6:0]  PC_Addr;
  logic        IR_Ld;
  logic [7:0]  D_Addr;
  logic        D_Wr;
  logic        RF_s;
  logic [3:0]  RF_W_Addr;
  logic        RF_W_En;
  logic [3:0]  RF_Ra_Addr;
  logic [3:0]  RF_Rb_Addr;
  logic [2:0]  ALU_Sel;
  logic [3:0]  State;
  logic        Halted;

  int checks   = 0;
  int failures = 0;

  control_unit dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .IR_In      (IR_In),
    .PC_Addr    (PC_Addr),
    .IR_Ld      (IR_Ld),
    .D_Addr     (D_Addr),
    .D_Wr       (D_Wr),
    .RF_s       (RF_s),
    .RF_W_Addr  (RF_W_Addr),
    .RF_W_En    (RF_W_En),
    .RF_Ra_Addr (RF_Ra_Addr),
    .RF_Rb_Addr (RF_Rb_Addr),
    .ALU_Sel    (ALU_Sel),
    .State      (State),
    .Halted     (Halted)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All write/fetch strobes packed for quick idle checks.
  function automatic logic [3:0] strobes();
    return {IR_Ld, D_Wr, RF_W_En, Halted};
  endfunction

  logic [3:0] ops  [6];
  logic [2:0] sels [6];

  initial begin
    ops  = '{4'h4, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
    sels = '{3'b010, 3'b100, 3'b101, 3'b110, 3'b111, 3'b011};
    Reset = 1'b1;
    IR_In = 16'h0000;
    tick();
    chk("rst_state", 16'(State), 16'd0);
    chk("rst_pc", 16'(PC_Addr), 16'd0);
    chk("rst_strobes", 16'(strobes()), 16'd0);
    chk("rst_addr", {D_Addr, RF_W_Addr, RF_Ra_Addr}, 16'd0);
    chk("rst_sel", 16'(ALU_Sel), 16'd0);
    Reset = 1'b0;

    // NOOP: INIT -> FETCH -> DECODE -> FETCH
    tick();
    chk("noop_fetch", {12'(State), 3'd0, IR_Ld}, {12'd1, 3'd0, 1'b1});
    chk("noop_fetch_pc", 16'(PC_Addr), 16'd0);
    tick();
    chk("noop_decode", {12'(State), 4'(strobes())}, {12'd2, 4'd0});
    chk("noop_decode_pc", 16'(PC_Addr), 16'd1);
    tick();
    chk("noop_back", 16'(State), 16'd1);

    // LOAD 21B3
    IR_In = 16'h21B3;
    tick();
    chk("ld_decode", 16'(State), 16'd2);
    tick();
    chk("ld_a_state", 16'(State), 16'd3);
    chk("ld_a_daddr", 16'(D_Addr), 16'h1B);
    chk("ld_a_ctl", {14'd0, RF_s, RF_W_En}, {14'd0, 1'b1, 1'b0});
    tick();
    chk("ld_b_state", 16'(State), 16'd4);
    chk("ld_b_ctl", {D_Addr, RF_W_Addr, RF_s, RF_W_En, 2'd0},
        {8'h1B, 4'd3, 1'b1, 1'b1, 2'd0});
    tick();
    chk("ld_done", {12'(State), 3'd0, RF_W_En}, {12'd1, 4'd0});
    chk("ld_pc", 16'(PC_Addr), 16'd2);

    // ADD 3125
    IR_In = 16'h3125;
    tick();
    tick();
    chk("add_state", 16'(State), 16'd6);
    chk("add_fields", {ALU_Sel, RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr, 1'b0},
        {3'b001, 4'd1, 4'd2, 4'd5, 1'b0});
    chk("add_ctl", {14'd0, RF_W_En, RF_s}, {14'd0, 1'b1, 1'b0});
    tick();
    chk("add_done", {9'(State), 3'(ALU_Sel), 3'd0, RF_W_En},
        {9'd1, 7'd0});

    // STORE 1A40
    IR_In = 16'h1A40;
    tick();
    tick();
    chk("st_state", 16'(State), 16'd5);
    chk("st_fields", {D_Addr, RF_Ra_Addr, 3'd0, D_Wr},
        {8'h40, 4'hA, 3'd0, 1'b1});
    tick();
    chk("st_done", {12'(State), 3'd0, D_Wr}, {12'd1, 4'd0});
    chk("st_pc", 16'(PC_Addr), 16'd4);

    // Remaining ALU opcodes
    for (int i = 0; i < 6; i++) begin
      IR_In = {ops[i], 12'h9C7};
      tick();
      tick();
      chk($sformatf("alu_op%0h", ops[i]),
          {ALU_Sel, RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr, 1'b0},
          {sels[i], 4'h9, 4'hC, 4'h7, 1'b0});
      tick();
    end
    chk("alu_pc", 16'(PC_Addr), 16'd10);

    // 117 NOOPs bring PC from 10 to 127, then wrap.
    IR_In = 16'h0000;
    repeat (234) tick();
    chk("pc_127", {12'(State), 4'd0}, {12'd1, 4'd0});
    chk("pc_127_val", 16'(PC_Addr), 16'd127);
    tick();
    chk("pc_wrap", 16'(PC_Addr), 16'd0);
    tick();

    // HALT 5000
    IR_In = 16'h5000;
    tick();
    chk("halt_pc", 16'(PC_Addr), 16'd1);
    tick();
    chk("halt_state", {12'(State), 4'(strobes())}, {12'd7, 4'b0001});
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_hold", {State, 5'(PC_Addr), 3'd0, 4'(strobes())},
          {4'd7, 5'd1, 3'd0, 4'b0001});
    end
    Reset = 1'b1;
    tick();
    chk("halt_rst", {State, 5'(PC_Addr), 3'd0, 4'(strobes())},
        {4'd0, 5'd0, 3'd0, 4'd0});
    Reset = 1'b0;

    // Reset in the middle of a LOAD
    tick();
    IR_In = 16'h21B3;
    tick();
    tick();
    chk("midld_a", 16'(State), 16'd3);
    Reset = 1'b1;
    tick();
    chk("midld_rst", {State, D_Addr, 2'd0, D_Wr, RF_W_En},
        {4'd0, 8'd0, 4'd0});
    Reset = 1'b0;

    // Undefined opcode F000
    tick();
    IR_In = 16'hF000;
    tick();
    chk("ill_pc", 16'(PC_Addr), 16'd1);
    tick();
`ifdef CU_TRAP_ILLEGAL_EN
    chk("ill_trap", {12'(State), 3'd0, Halted}, {12'd7, 3'd0, 1'b1});
`else
    chk("ill_noop", {12'(State), 3'd0, Halted}, {12'd1, 4'd0});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
